axis_demux_2: RTL and testbench
===============================

Name: axis_demux_2

Overview:
- One AXI-Stream slave input feeds two AXI-Stream master outputs. The destination is chosen per packet by `sel`.
- This block is the fan-out counterpart of the 2:1 AXIS mux, and sits on the receive side of the same stream fabric.
- The route is locked on the first beat of each packet and held until the TLAST beat is accepted.
- One registered pipeline stage gives full throughput with 1-cycle latency.

Parameters:
- DATA_W, 8: width of TDATA on the input and both outputs.

Ports:
- ACLK  in  1  clock; all logic on rising edge
- ARESETn  in  1  synchronous reset, active-low
- sel  in  1  destination for next packet (0 → m0, 1 → m1); sampled only on the first beat of a packet
- s_tdata  in  DATA_W  input stream data
- s_tvalid  in  1  input beat valid
- s_tlast  in  1  input last beat of packet
- s_tready  out  1  demux can accept an input beat
- m0_tdata  out  DATA_W  output 0 data
- m0_tvalid  out  1  output 0 beat valid
- m0_tlast  out  1  output 0 last beat
- m0_tready  in  1  output 0 sink ready
- m1_tdata  out  DATA_W  output 1 data
- m1_tvalid  out  1  output 1 beat valid
- m1_tlast  out  1  output 1 last beat
- m1_tready  in  1  output 1 sink ready

Behaviour:
- Reset: the synchronous reset (ARESETn low at a rising ACLK edge) clears:
  - the output register: full=0, data=0, last=0, dest=0;
  - the route state to IDLE.
  - Outputs during and after reset: m0_tvalid=m1_tvalid=0, m0/m1_tdata=0, m0/m1_tlast=0. s_tready=1 from the first cycle after reset release.
- Output register: single entry holding {data, last, dest, full}.
  - m0_tvalid = full & ~dest; m1_tvalid = full & dest.
  - Both m*_tdata and m*_tlast are driven from the register; they are only meaningful while that output's tvalid is high.
- Drain: `drain = full & (dest ? m1_tready : m0_tready)`.
- Input ready: `s_tready = ~full | drain`, combinational. Held low while full and the selected sink stalls.
- Accept: `accept = s_tvalid & s_tready`. On accept the register loads s_tdata and s_tlast, full<=1, and dest <= route.
- Latency: an accepted beat appears on the selected output the next cycle. Back-to-back beats sustain 1 beat/cycle when the sink holds tready=1.
- Simultaneous drain and accept: the register reloads and full stays 1. Drain without accept gives full<=0.
- Route state machine:
  - IDLE: route = sel (live). On accept with s_tlast=0 → PKT, route_q<=sel. On accept with s_tlast=1 (single-beat packet) → stay IDLE.
  - PKT: route = route_q. sel is ignored. On accept with s_tlast=1 → IDLE.
- sel changes mid-packet have no effect. The change applies to the next packet's first accepted beat.
- The non-selected output never asserts tvalid. Its tready is ignored and never gates s_tready.
- AXIS stability: once mX_tvalid=1, the data, last and valid of that output hold until handshake.
- Mid-packet reset: register and state flush; a partially delivered packet is truncated without a TLAST. The next accepted beat is treated as a first beat and samples sel.

Optional Feature:
- Macro AXIS_DEMUX_PKT_CNT_EN.
- When defined, add two outputs: pkt_cnt_0 (out, 16) and pkt_cnt_1 (out, 16).
  - Each counts completed packets delivered on its output, incrementing on m0 (or m1) tvalid & tready & tlast.
  - Both reset to 0, wrap from 0xFFFF to 0, and have no saturation.
- When undefined, neither the ports nor the counter logic exist. All other behaviour is identical.

Decomposition:
- Shared package `axis_pkg`:
  - route state encoding (`ST_IDLE`=1'b0, `ST_PKT`=1'b1);
  - destination constants (`DEST_0`=1'b0, `DEST_1`=1'b1);
  - default `DATA_W`.
- Sub-module `axis_reg_slice`: one-entry AXIS register carrying {data, last, dest}, with full/drain logic as above. The demux instantiates it once and adds the route FSM and valid decode.

Test Plan:
- Reset release, s_tvalid=0 → m0_tvalid=m1_tvalid=0, s_tready=1, all tdata=0.
- sel=0, stream 8 beats (0x10..0x17, TLAST on 0x17), both treadys=1 → m0 shows 0x10..0x17 one cycle later, one beat/cycle, m0_tlast with 0x17; m1_tvalid stays 0.
- Start a packet with sel=1, toggle sel to 0 after beat 2, 4-beat packet → all 4 beats on m1. The next packet, with sel=0, goes to m0.
- sel=1, m1_tready=0 for 3 cycles after first beat 0xA5 → m1_tdata holds 0xA5 with tvalid=1, s_tready=0. Releasing tready drains 0xA5 and resumes with no loss or duplication. m0_tready toggling has no effect.
- Single-beat packets 0x01 (sel=0, tlast=1) then 0x02 (sel=1, tlast=1) on consecutive cycles → 0x01 on m0 then 0x02 on m1, each with tlast=1.
- ARESETn low for one edge mid-packet (after beat 3 of 8) → outputs invalid next cycle. The next beat with sel=1 routes to m1. With AXIS_DEMUX_PKT_CNT_EN defined, counters read 0 after reset and increment by 1 per completed packet.

Source files
------------

// File: rtl/axis_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : axis_pkg
//  Description : Shared constants for the AXI-Stream demux fabric.
//  Revision    : 1.0 - initial release
// ============================================================================
package axis_pkg;

    localparam logic [0:0] ST_IDLE     = 1'b0;
    localparam logic [0:0] ST_PKT      = 1'b1;

    localparam logic [0:0] DEST_0      = 1'b0;
    localparam logic [0:0] DEST_1      = 1'b1;

    localparam int         DATA_W_DFLT = 8;

endpackage : axis_pkg
`default_nettype wire

// File: rtl/axis_reg_slice.sv
`default_nettype none
// ============================================================================
//  Module      : axis_reg_slice
//  Description : One-entry AXIS register carrying {data, last, dest}; drains
//                only through the sink selected by the stored destination.
//  Revision    : 1.0 - initial release
// ============================================================================
module axis_reg_slice
    import axis_pkg::*;
#(
    parameter int DATA_W = DATA_W_DFLT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] i_s_data,
    input  logic              i_s_last,
    input  logic              i_s_dest,
    input  logic              i_s_valid,
    output logic              o_s_ready,
    output logic [DATA_W-1:0] o_m_data,
    output logic              o_m_last,
    output logic              o_m_dest,
    output logic              o_m_full,
    input  logic              i_m_ready_0,
    input  logic              i_m_ready_1
);

    logic [DATA_W-1:0] r_data;
    logic              r_last;
    logic              r_dest;
    logic              r_full;

    logic              w_drain;
    logic              w_accept;

    // The idle sink's ready is masked out so it can never gate the input.
    assign w_drain   = r_full & ((r_dest == DEST_1) ? i_m_ready_1 : i_m_ready_0);
    assign o_s_ready = ~r_full | w_drain;
    assign w_accept  = i_s_valid & o_s_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_data <= '0;
            r_last <= 1'b0;
            r_dest <= DEST_0;
            r_full <= 1'b0;
        end else if (w_accept) begin
            r_data <= i_s_data;
            r_last <= i_s_last;
            r_dest <= i_s_dest;
            r_full <= 1'b1;
        end else if (w_drain) begin
            r_full <= 1'b0;
        end
    end

    assign o_m_data = r_data;
    assign o_m_last = r_last;
    assign o_m_dest = r_dest;
    assign o_m_full = r_full;

endmodule : axis_reg_slice
`default_nettype wire

// File: rtl/axis_demux_2.sv
`default_nettype none
// ============================================================================
//  Module      : axis_demux_2
//  Description : 1:2 AXI-Stream demux, route locked per packet, 1-cycle latency.
//                Define AXIS_DEMUX_PKT_CNT_EN to add per-output packet counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module axis_demux_2
    import axis_pkg::*;
#(
    parameter int DATA_W = DATA_W_DFLT
) (
    input  logic              ACLK,
    input  logic              ARESETn,
    input  logic              sel,
    input  logic [DATA_W-1:0] s_tdata,
    input  logic              s_tvalid,
    input  logic              s_tlast,
    output logic              s_tready,
    output logic [DATA_W-1:0] m0_tdata,
    output logic              m0_tvalid,
    output logic              m0_tlast,
    input  logic              m0_tready,
    output logic [DATA_W-1:0] m1_tdata,
    output logic              m1_tvalid,
    output logic              m1_tlast,
    input  logic              m1_tready
`ifdef AXIS_DEMUX_PKT_CNT_EN
    ,
    output logic [15:0]       pkt_cnt_0,
    output logic [15:0]       pkt_cnt_1
`endif
);

    logic [0:0]        r_state;
    logic              r_route_q;

    logic              w_rst;
    logic              w_route;
    logic              w_accept;
    logic [DATA_W-1:0] w_data;
    logic              w_last;
    logic              w_dest;
    logic              w_full;

    assign w_rst    = ~ARESETn;
    assign w_accept = s_tvalid & s_tready;
    // sel is live only for the first beat; afterwards the latched route rules.
    assign w_route  = (r_state == ST_IDLE) ? sel : r_route_q;

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            r_state   <= ST_IDLE;
            r_route_q <= DEST_0;
        end else if (w_accept) begin
            case (r_state)
                ST_IDLE: begin
                    if (!s_tlast) begin
                        r_state   <= ST_PKT;
                        r_route_q <= sel;
                    end
                end
                default: begin
                    if (s_tlast) begin
                        r_state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    axis_reg_slice #(
        .DATA_W      (DATA_W)
    ) u_reg_slice (
        .clk         (ACLK),
        .rst         (w_rst),
        .i_s_data    (s_tdata),
        .i_s_last    (s_tlast),
        .i_s_dest    (w_route),
        .i_s_valid   (s_tvalid),
        .o_s_ready   (s_tready),
        .o_m_data    (w_data),
        .o_m_last    (w_last),
        .o_m_dest    (w_dest),
        .o_m_full    (w_full),
        .i_m_ready_0 (m0_tready),
        .i_m_ready_1 (m1_tready)
    );

    assign m0_tvalid = w_full & (w_dest == DEST_0);
    assign m1_tvalid = w_full & (w_dest == DEST_1);
    assign m0_tdata  = w_data;
    assign m1_tdata  = w_data;
    assign m0_tlast  = w_last;
    assign m1_tlast  = w_last;

`ifdef AXIS_DEMUX_PKT_CNT_EN
    logic [15:0] r_pkt_cnt_0;
    logic [15:0] r_pkt_cnt_1;

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            r_pkt_cnt_0 <= '0;
            r_pkt_cnt_1 <= '0;
        end else begin
            if (m0_tvalid & m0_tready & m0_tlast) r_pkt_cnt_0 <= r_pkt_cnt_0 + 16'd1;
            if (m1_tvalid & m1_tready & m1_tlast) r_pkt_cnt_1 <= r_pkt_cnt_1 + 16'd1;
        end
    end

    assign pkt_cnt_0 = r_pkt_cnt_0;
    assign pkt_cnt_1 = r_pkt_cnt_1;
`endif

endmodule : axis_demux_2
`default_nettype wire

// File: tb/tb_axis_demux_2.sv
`default_nettype none
// ============================================================================
//  Module      : tb_axis_demux_2
//  Description : Directed self-checking bench for axis_demux_2.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_axis_demux_2;

    logic       ACLK;
    logic       ARESETn;
    logic       sel;
    logic [7:0] s_tdata;
    logic       s_tvalid;
    logic       s_tlast;
    logic       s_tready;
    logic [7:0] m0_tdata;
    logic       m0_tvalid;
    logic       m0_tlast;
    logic       m0_tready;
    logic [7:0] m1_tdata;
    logic       m1_tvalid;
    logic       m1_tlast;
    logic       m1_tready;
`ifdef AXIS_DEMUX_PKT_CNT_EN
    logic [15:0] pkt_cnt_0;
    logic [15:0] pkt_cnt_1;
`endif

    int n_total = 0;
    int n_pass  = 0;

    axis_demux_2 #(.DATA_W(8)) dut (
        .ACLK      (ACLK),
        .ARESETn   (ARESETn),
        .sel       (sel),
        .s_tdata   (s_tdata),
        .s_tvalid  (s_tvalid),
        .s_tlast   (s_tlast),
        .s_tready  (s_tready),
        .m0_tdata  (m0_tdata),
        .m0_tvalid (m0_tvalid),
        .m0_tlast  (m0_tlast),
        .m0_tready (m0_tready),
        .m1_tdata  (m1_tdata),
        .m1_tvalid (m1_tvalid),
        .m1_tlast  (m1_tlast),
        .m1_tready (m1_tready)
`ifdef AXIS_DEMUX_PKT_CNT_EN
        ,
        .pkt_cnt_0 (pkt_cnt_0),
        .pkt_cnt_1 (pkt_cnt_1)
`endif
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    task automatic cyc();
        @(posedge ACLK);
        #2;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%02h expected=0x%02h", tag, obs, exp);
    endtask

    task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    initial begin
        ARESETn   = 1'b0;
        sel       = 1'b0;
        s_tdata   = 8'h00;
        s_tvalid  = 1'b0;
        s_tlast   = 1'b0;
        m0_tready = 1'b1;
        m1_tready = 1'b1;

        // Reset
        cyc(); cyc(); cyc();
        chk1("rst_m0_valid", m0_tvalid, 1'b0);
        chk1("rst_m1_valid", m1_tvalid, 1'b0);
        chk8("rst_m0_data", m0_tdata, 8'h00);
        chk8("rst_m1_data", m1_tdata, 8'h00);
        chk1("rst_m0_last", m0_tlast, 1'b0);
        ARESETn = 1'b1;
        cyc();
        chk1("rel_s_ready", s_tready, 1'b1);
        chk1("rel_m0_valid", m0_tvalid, 1'b0);
        chk1("rel_m1_valid", m1_tvalid, 1'b0);

        // 8-beat packet to m0 at full rate
        sel = 1'b0;
        for (int i = 0; i < 8; i++) begin
            s_tdata  = 8'(8'h10 + i);
            s_tvalid = 1'b1;
            s_tlast  = (i == 7);
            #1;
            chk1("p8_s_ready", s_tready, 1'b1);
            cyc();
            chk1("p8_m0_valid", m0_tvalid, 1'b1);
            chk8("p8_m0_data", m0_tdata, 8'(8'h10 + i));
            chk1("p8_m0_last", m0_tlast, (i == 7));
            chk1("p8_m1_valid", m1_tvalid, 1'b0);
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        cyc();
        chk1("p8_m0_idle", m0_tvalid, 1'b0);

        // Mid-packet sel toggle is ignored
        for (int i = 0; i < 4; i++) begin
            sel      = (i < 2);
            s_tdata  = 8'(8'h20 + i);
            s_tvalid = 1'b1;
            s_tlast  = (i == 3);
            cyc();
            chk1("lock_m1_valid", m1_tvalid, 1'b1);
            chk1("lock_m0_valid", m0_tvalid, 1'b0);
            chk8("lock_m1_data", m1_tdata, 8'(8'h20 + i));
        end
        chk1("lock_m1_last", m1_tlast, 1'b1);
        sel = 1'b0;
        for (int i = 0; i < 2; i++) begin
            s_tdata = 8'(8'h30 + i);
            s_tlast = (i == 1);
            cyc();
            chk1("next_m0_valid", m0_tvalid, 1'b1);
            chk1("next_m1_valid", m1_tvalid, 1'b0);
            chk8("next_m0_data", m0_tdata, 8'(8'h30 + i));
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        cyc();

        // Backpressure on m1; m0_tready wiggles without effect
        sel       = 1'b1;
        m1_tready = 1'b0;
        s_tdata   = 8'hA5;
        s_tvalid  = 1'b1;
        s_tlast   = 1'b0;
        cyc();
        s_tdata = 8'hA6;
        s_tlast = 1'b1;
        for (int k = 0; k < 3; k++) begin
            m0_tready = k[0];
            #1;
            chk1("stall_s_ready", s_tready, 1'b0);
            chk1("stall_m1_valid", m1_tvalid, 1'b1);
            chk8("stall_m1_data", m1_tdata, 8'hA5);
            chk1("stall_m0_valid", m0_tvalid, 1'b0);
            cyc();
        end
        m0_tready = 1'b1;
        m1_tready = 1'b1;
        #1;
        chk1("unstall_s_ready", s_tready, 1'b1);
        cyc();
        chk1("unstall_m1_valid", m1_tvalid, 1'b1);
        chk8("unstall_m1_data", m1_tdata, 8'hA6);
        chk1("unstall_m1_last", m1_tlast, 1'b1);
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        cyc();
        chk1("unstall_drained", m1_tvalid, 1'b0);

        // Back-to-back single-beat packets
        sel      = 1'b0;
        s_tdata  = 8'h01;
        s_tvalid = 1'b1;
        s_tlast  = 1'b1;
        cyc();
        chk1("sb1_m0_valid", m0_tvalid, 1'b1);
        chk8("sb1_m0_data", m0_tdata, 8'h01);
        chk1("sb1_m0_last", m0_tlast, 1'b1);
        chk1("sb1_m1_valid", m1_tvalid, 1'b0);
        sel     = 1'b1;
        s_tdata = 8'h02;
        cyc();
        chk1("sb2_m1_valid", m1_tvalid, 1'b1);
        chk8("sb2_m1_data", m1_tdata, 8'h02);
        chk1("sb2_m1_last", m1_tlast, 1'b1);
        chk1("sb2_m0_valid", m0_tvalid, 1'b0);
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        cyc();
`ifdef AXIS_DEMUX_PKT_CNT_EN
        chk16("cnt0_pre", pkt_cnt_0, 16'd3);
        chk16("cnt1_pre", pkt_cnt_1, 16'd3);
`endif

        // Reset in the middle of a packet to m0
        sel = 1'b0;
        for (int i = 0; i < 3; i++) begin
            s_tdata  = 8'(8'h40 + i);
            s_tvalid = 1'b1;
            s_tlast  = 1'b0;
            cyc();
        end
        chk8("mid_m0_data", m0_tdata, 8'h42);
        s_tvalid = 1'b0;
        ARESETn  = 1'b0;
        cyc();
        chk1("mid_rst_m0_valid", m0_tvalid, 1'b0);
        chk1("mid_rst_m1_valid", m1_tvalid, 1'b0);
        chk8("mid_rst_m0_data", m0_tdata, 8'h00);
`ifdef AXIS_DEMUX_PKT_CNT_EN
        chk16("cnt0_rst", pkt_cnt_0, 16'd0);
        chk16("cnt1_rst", pkt_cnt_1, 16'd0);
`endif
        ARESETn  = 1'b1;
        sel      = 1'b1;
        s_tdata  = 8'h50;
        s_tvalid = 1'b1;
        s_tlast  = 1'b1;
        #1;
        chk1("post_rst_s_ready", s_tready, 1'b1);
        cyc();
        chk1("post_rst_m1_valid", m1_tvalid, 1'b1);
        chk1("post_rst_m0_valid", m0_tvalid, 1'b0);
        chk8("post_rst_m1_data", m1_tdata, 8'h50);
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        cyc();
        chk1("post_rst_drained", m1_tvalid, 1'b0);
`ifdef AXIS_DEMUX_PKT_CNT_EN
        chk16("cnt0_post", pkt_cnt_0, 16'd0);
        chk16("cnt1_post", pkt_cnt_1, 16'd1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_axis_demux_2
`default_nettype wire
